// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator: issues one cache request per instruction, holds it until
// the cache completes or times out, and aligns/extends data between pipeline and byte lanes.
module mem_access_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_is_load,
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_address,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [4:0]      i_rd,
    output logic            o_stall,
    output logic            o_wb_valid,
    output logic [XLEN-1:0] o_wb_data,
    output logic [4:0]      o_wb_rd,
    output logic            o_store_done,
    output logic            o_exc_valid,
    output logic [1:0]      o_exc_cause,
    output logic            o_cache_req,
    output logic [XLEN-1:0] o_cache_address,
    output logic [XLEN-1:0] o_cache_write_data,
    output logic            o_cache_rw,
    output logic [1:0]      o_cache_size,
    output logic [3:0]      o_cache_byte_en,
    input  logic [XLEN-1:0] i_cache_data,
    input  logic            i_cache_done
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeNone = 2'b11;

    state_e state_q, state_d;

    logic [15:0]     cnt_q;
    logic            is_load_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] address_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      byte_en_q;
    logic [1:0]      size_q;
    logic [4:0]      rd_q;
    logic            wb_valid_q, store_done_q, exc_valid_q;
    logic [XLEN-1:0] wb_data_q;
    logic [4:0]      wb_rd_q;
    logic [1:0]      exc_cause_q;

    logic            accept, width_ok, misaligned, legal, timeout;
    logic [1:0]      acc_size;
    logic [3:0]      acc_byte_en;
    logic [XLEN-1:0] acc_wdata, masked_store;
    logic [XLEN-1:0] lane, load_ext;
    logic [16:0]     cnt_inc;

    assign accept = (state_q == StIdle) && i_valid && (i_is_load || i_is_store);

    // Width decode; unsigned variants (100/101) exist only for loads.
    always_comb begin
        width_ok = 1'b0;
        acc_size = SizeNone;
        case (i_funct3)
            3'b000: begin width_ok = 1'b1;      acc_size = SizeByte; end
            3'b001: begin width_ok = 1'b1;      acc_size = SizeHalf; end
            3'b010: begin width_ok = 1'b1;      acc_size = SizeWord; end
            3'b100: begin width_ok = i_is_load; acc_size = SizeByte; end
            3'b101: begin width_ok = i_is_load; acc_size = SizeHalf; end
            default: ;
        endcase
    end

    assign misaligned = ((acc_size == SizeHalf) && i_address[0]) ||
                        ((acc_size == SizeWord) && (i_address[1:0] != 2'b00));
    assign legal      = accept && width_ok && !misaligned;

    always_comb begin
        acc_byte_en  = 4'b0000;
        masked_store = '0;
        case (acc_size)
            SizeByte: begin
                acc_byte_en  = 4'b0001 << i_address[1:0];
                masked_store = {{(XLEN-8){1'b0}}, i_store_data[7:0]};
            end
            SizeHalf: begin
                acc_byte_en  = 4'b0011 << i_address[1:0];
                masked_store = {{(XLEN-16){1'b0}}, i_store_data[15:0]};
            end
            SizeWord: begin
                acc_byte_en  = 4'b1111;
                masked_store = i_store_data;
            end
            default: ;
        endcase
    end

    assign acc_wdata = masked_store << {i_address[1:0], 3'b000};

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    // A done in the same cycle takes precedence over the timeout.
    assign timeout = (state_q == StReq) && !i_cache_done && (cnt_inc == 17'(TIMEOUT_CYCLES));

    assign lane = i_cache_data >> {addr_lo_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (legal) state_d = StReq;
            StReq:   if (i_cache_done || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_cache_req        = (state_q == StReq);
        o_cache_size       = o_cache_req ? size_q : SizeNone;
        o_cache_address    = o_cache_req ? address_q : '0;
        o_cache_write_data = o_cache_req ? wdata_q : '0;
        o_cache_rw         = o_cache_req && !is_load_q;
        o_cache_byte_en    = o_cache_req ? byte_en_q : 4'b0000;
        o_stall            = o_cache_req || legal;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            address_q    <= '0;
            wdata_q      <= '0;
            byte_en_q    <= 4'b0000;
            size_q       <= SizeNone;
            rd_q         <= 5'd0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= 5'd0;
            store_done_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= 2'b00;
        end else begin
            wb_valid_q   <= 1'b0;
            store_done_q <= 1'b0;
            exc_valid_q  <= 1'b0;
            if (accept) begin
                if (!width_ok) begin
                    exc_valid_q <= 1'b1;
                    exc_cause_q <= 2'b00;
                end else if (misaligned) begin
                    exc_valid_q <= 1'b1;
                    exc_cause_q <= i_is_load ? 2'b01 : 2'b10;
                end else begin
                    cnt_q     <= '0;
                    is_load_q <= i_is_load;
                    funct3_q  <= i_funct3;
                    addr_lo_q <= i_address[1:0];
                    address_q <= {i_address[XLEN-1:2], 2'b00};
                    wdata_q   <= i_is_load ? '0 : acc_wdata;
                    byte_en_q <= acc_byte_en;
                    size_q    <= acc_size;
                    rd_q      <= i_rd;
                end
            end
            if (state_q == StReq) begin
                if (i_cache_done) begin
                    if (is_load_q) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_ext;
                        wb_rd_q    <= rd_q;
                    end else begin
                        store_done_q <= 1'b1;
                    end
                end else if (timeout) begin
                    exc_valid_q <= 1'b1;
                    exc_cause_q <= 2'b11;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    assign o_wb_valid   = wb_valid_q;
    assign o_wb_data    = wb_data_q;
    assign o_wb_rd      = wb_rd_q;
    assign o_store_done = store_done_q;
    assign o_exc_valid  = exc_valid_q;
    assign o_exc_cause  = exc_cause_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of accesses with a scoreboard of expected pulses,
// plus hand-written reset-abort sequence.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_is_load, i_is_store, i_cache_done;
    logic [2:0]  i_funct3;
    logic [31:0] i_address, i_store_data, i_cache_data;
    logic [4:0]  i_rd;
    logic        o_stall, o_wb_valid, o_store_done, o_exc_valid, o_cache_req, o_cache_rw;
    logic [31:0] o_wb_data, o_cache_address, o_cache_write_data;
    logic [4:0]  o_wb_rd;
    logic [1:0]  o_exc_cause, o_cache_size;
    logic [3:0]  o_cache_byte_en;

    int errors = 0;
    int checks = 0;

    // kind: 0 load writeback, 1 store done, 2 exception
    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic [31:0] cdata;
        int          delay;
        int          kind;
        logic [1:0]  cause;
        logic [31:0] wb;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  size;
    } vec_t;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  cause;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_valid            (i_valid),
        .i_is_load          (i_is_load),
        .i_is_store         (i_is_store),
        .i_funct3           (i_funct3),
        .i_address          (i_address),
        .i_store_data       (i_store_data),
        .i_rd               (i_rd),
        .o_stall            (o_stall),
        .o_wb_valid         (o_wb_valid),
        .o_wb_data          (o_wb_data),
        .o_wb_rd            (o_wb_rd),
        .o_store_done       (o_store_done),
        .o_exc_valid        (o_exc_valid),
        .o_exc_cause        (o_exc_cause),
        .o_cache_req        (o_cache_req),
        .o_cache_address    (o_cache_address),
        .o_cache_write_data (o_cache_write_data),
        .o_cache_rw         (o_cache_rw),
        .o_cache_size       (o_cache_size),
        .o_cache_byte_en    (o_cache_byte_en),
        .i_cache_data       (i_cache_data),
        .i_cache_done       (i_cache_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [4:0] rd, input logic [31:0] cdata, input int delay,
                                input int kind, input logic [1:0] cause, input logic [31:0] wb,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [1:0] size);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rd = rd;
        v.cdata = cdata; v.delay = delay; v.kind = kind; v.cause = cause; v.wb = wb;
        v.be = be; v.wdata = wdata; v.size = size;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_wb_valid || o_store_done || o_exc_valid) begin
            int   act_kind;
            exp_t e;
            act_kind = ({o_wb_valid, o_store_done, o_exc_valid} == 3'b100) ? 0 :
                       ({o_wb_valid, o_store_done, o_exc_valid} == 3'b010) ? 1 :
                       ({o_wb_valid, o_store_done, o_exc_valid} == 3'b001) ? 2 : 3;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got wb=%b sd=%b exc=%b expected no pulse",
                         o_wb_valid, o_store_done, o_exc_valid);
            end else begin
                e = sb_q.pop_front();
                if (act_kind != e.kind ||
                    (e.kind == 0 && (o_wb_data !== e.data || o_wb_rd !== e.rd)) ||
                    (e.kind == 2 && o_exc_cause !== e.cause)) begin
                    errors++;
                    $display("FAIL sb_result: got kind=%0d data=%h rd=%0d cause=%b expected kind=%0d data=%h rd=%0d cause=%b",
                             act_kind, o_wb_data, o_wb_rd, o_exc_cause,
                             e.kind, e.data, e.rd, e.cause);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   n_req;
        exp_t e;
        logic [2:0] exp_pulse;
        @(negedge clk);
        i_valid = 1'b1; i_is_load = v.ld; i_is_store = v.st; i_funct3 = v.f3;
        i_address = v.addr; i_store_data = v.sdata; i_rd = v.rd;
        #1;
        chk("accept_stall", {31'd0, o_stall}, {31'd0, (v.kind != 2 || v.cause == 2'b11)});
        e.kind = v.kind; e.data = v.wb; e.rd = v.rd; e.cause = v.cause;
        sb_q.push_back(e);
        @(negedge clk);
        i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
        if (v.kind != 2 || v.cause == 2'b11) begin
            n_req = (v.delay == 0) ? TO : v.delay;
            for (int k = 1; k <= n_req; k++) begin
                chk("req_active", {31'd0, o_cache_req}, 32'd1);
                chk("req_stall", {31'd0, o_stall}, 32'd1);
                chk("req_addr", o_cache_address, v.addr & 32'hFFFF_FFFC);
                chk("req_byte_en", {28'd0, o_cache_byte_en}, {28'd0, v.be});
                chk("req_size", {30'd0, o_cache_size}, {30'd0, v.size});
                chk("req_rw", {31'd0, o_cache_rw}, {31'd0, (v.kind == 1)});
                if (v.kind == 1) chk("req_wdata", o_cache_write_data, v.wdata);
                if (k == v.delay) begin
                    i_cache_done = 1'b1;
                    i_cache_data = v.cdata;
                end
                @(negedge clk);
                i_cache_done = 1'b0;
                i_cache_data = 32'h5555_5555;
            end
        end else begin
            chk("exc_no_req", {31'd0, o_cache_req}, 32'd0);
        end
        exp_pulse = (v.kind == 0) ? 3'b100 : (v.kind == 1) ? 3'b010 : 3'b001;
        chk("pulse_timing", {29'd0, o_wb_valid, o_store_done, o_exc_valid}, {29'd0, exp_pulse});
        chk("idle_req", {31'd0, o_cache_req}, 32'd0);
        chk("idle_size", {30'd0, o_cache_size}, 32'd3);
        chk("idle_stall", {31'd0, o_stall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0; i_funct3 = 3'b000;
        i_address = '0; i_store_data = '0; i_rd = '0; i_cache_data = '0; i_cache_done = 1'b0;

        //  ld st f3      addr      sdata         rd     cdata         dly kind cause wb            be       wdata         size
        add(1, 0, 3'b010, 32'h100, 32'h0,        5'd5,  32'hDEADBEEF, 3,  0,   2'b00, 32'hDEADBEEF, 4'b1111, 32'h0,        2'b10);
        add(1, 0, 3'b000, 32'h203, 32'h0,        5'd6,  32'h80112233, 1,  0,   2'b00, 32'hFFFFFF80, 4'b1000, 32'h0,        2'b00);
        add(1, 0, 3'b100, 32'h203, 32'h0,        5'd7,  32'h80112233, 2,  0,   2'b00, 32'h00000080, 4'b1000, 32'h0,        2'b00);
        add(1, 0, 3'b001, 32'h202, 32'h0,        5'd8,  32'h80112233, 1,  0,   2'b00, 32'hFFFF8011, 4'b1100, 32'h0,        2'b01);
        add(0, 1, 3'b000, 32'h101, 32'h000000AB, 5'd0,  32'h0,        2,  1,   2'b00, 32'h0,        4'b0010, 32'h0000AB00, 2'b00);
        add(1, 0, 3'b010, 32'h102, 32'h0,        5'd1,  32'h0,        1,  2,   2'b01, 32'h0,        4'b0000, 32'h0,        2'b11);
        add(0, 1, 3'b001, 32'h001, 32'h1234,     5'd0,  32'h0,        1,  2,   2'b10, 32'h0,        4'b0000, 32'h0,        2'b11);
        add(1, 0, 3'b010, 32'h400, 32'h0,        5'd2,  32'h0,        0,  2,   2'b11, 32'h0,        4'b1111, 32'h0,        2'b10);
        add(1, 0, 3'b010, 32'h404, 32'h0,        5'd9,  32'h12345678, 4,  0,   2'b00, 32'h12345678, 4'b1111, 32'h0,        2'b10);
        add(0, 1, 3'b001, 32'h402, 32'hFFFF1234, 5'd0,  32'h0,        1,  1,   2'b00, 32'h0,        4'b1100, 32'h12340000, 2'b01);
        add(1, 0, 3'b101, 32'h0FE, 32'h0,        5'd10, 32'hBEEF0000, 1,  0,   2'b00, 32'h0000BEEF, 4'b1100, 32'h0,        2'b01);
        add(0, 1, 3'b100, 32'h200, 32'h0,        5'd0,  32'h0,        1,  2,   2'b00, 32'h0,        4'b0000, 32'h0,        2'b11);
        add(1, 0, 3'b011, 32'h200, 32'h0,        5'd4,  32'h0,        1,  2,   2'b00, 32'h0,        4'b0000, 32'h0,        2'b11);
        add(1, 1, 3'b010, 32'h500, 32'h77777777, 5'd31, 32'hCAFEF00D, 1,  0,   2'b00, 32'hCAFEF00D, 4'b1111, 32'h0,        2'b10);
        add(1, 0, 3'b001, 32'h201, 32'h0,        5'd3,  32'h0,        1,  2,   2'b01, 32'h0,        4'b0000, 32'h0,        2'b11);
        add(0, 1, 3'b000, 32'h003, 32'hFFFFFF5A, 5'd0,  32'h0,        1,  1,   2'b00, 32'h0,        4'b1000, 32'h5A000000, 2'b00);

        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, o_cache_req}, 32'd0);
        chk("rst_size", {30'd0, o_cache_size}, 32'd3);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_pulses", {29'd0, o_wb_valid, o_store_done, o_exc_valid}, 32'd0);
        chk("rst_byte_en", {28'd0, o_cache_byte_en}, 32'd0);
        i_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset during the second REQ cycle abandons the access; later dones are ignored.
        @(negedge clk);
        i_valid = 1'b1; i_is_load = 1'b1; i_funct3 = 3'b010; i_address = 32'h300; i_rd = 5'd12;
        @(negedge clk);
        i_valid = 1'b0; i_is_load = 1'b0;
        chk("abort_req1", {31'd0, o_cache_req}, 32'd1);
        @(negedge clk);
        chk("abort_req2", {31'd0, o_cache_req}, 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("abort_req", {31'd0, o_cache_req}, 32'd0);
        chk("abort_size", {30'd0, o_cache_size}, 32'd3);
        chk("abort_stall", {31'd0, o_stall}, 32'd0);
        chk("abort_pulses", {29'd0, o_wb_valid, o_store_done, o_exc_valid}, 32'd0);
        i_cache_done = 1'b1; i_cache_data = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_pulses", {29'd0, o_wb_valid, o_store_done, o_exc_valid}, 32'd0);
            chk("late_done_req", {31'd0, o_cache_req}, 32'd0);
        end
        i_cache_done = 1'b0;
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage initiator for the data cache: accepts one load/store per instruction from the execute/memory pipeline boundary and issues it on the cache request interface.
- Holds the request until the cache signals done, stalling the pipeline while it waits.
- Aligns store data to byte lanes, and extracts and sign/zero-extends load data.
- Reports misaligned-access, illegal-width and timeout exceptions.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ before a timeout exception is raised (1..65535).

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  pipeline presents a memory instruction this cycle.
- i_is_load  in  1  instruction is a load.
- i_is_store  in  1  instruction is a store.
- i_funct3  in  3  access width/sign (RV32I encoding).
- i_address  in  XLEN  effective byte address.
- i_store_data  in  XLEN  rs2 value (unaligned, in low bits).
- i_rd  in  5  load destination register.
- o_stall  out  1  pipeline must hold the memory-stage instruction.
- o_wb_valid  out  1  one-cycle pulse: load result valid.
- o_wb_data  out  XLEN  extended load result.
- o_wb_rd  out  5  destination for o_wb_data.
- o_store_done  out  1  one-cycle pulse: store completed.
- o_exc_valid  out  1  one-cycle exception pulse.
- o_exc_cause  out  2  00 illegal width, 01 misaligned load, 10 misaligned store, 11 timeout.
- o_cache_req  out  1  request active.
- o_cache_address  out  XLEN  request address (word-aligned: i_address with bits[1:0] cleared).
- o_cache_write_data  out  XLEN  lane-aligned store data.
- o_cache_rw  out  1  0 read, 1 write.
- o_cache_size  out  2  00 byte, 01 half, 10 word, 11 none (driven 11 whenever o_cache_req=0).
- o_cache_byte_en  out  4  byte lanes written/read.
- i_cache_data  in  XLEN  word-aligned read data.
- i_cache_done  in  1  cache completion, sampled only in REQ.

Behaviour:
- Reset values: all outputs 0, except o_cache_size=11. State is IDLE, timeout counter is 0.
- Reset mid-request abandons the access: no writeback, no exception, o_cache_req=0 on the next cycle.
- States are IDLE and REQ.
- Accept: IDLE & i_valid & (i_is_load | i_is_store). i_is_load has priority if both are set.
- Width check:
  - Legal loads: funct3 000/001/010/100/101.
  - Legal stores: funct3 000/001/010.
  - Anything else pulses o_exc_valid with cause 00 on the next cycle; no request is issued.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]!=00.
  - Pulses o_exc_valid the next cycle with cause 01 (load) or 10 (store); no request is issued; state stays IDLE.
- Legal accept:
  - Registers request fields and moves to REQ. o_cache_req=1 from the next cycle.
  - All request outputs are held stable throughout REQ.
- Byte enables: 0001<<a for byte, 0011<<a for half, 1111 for word, where a = addr[1:0].
- Store lane alignment: write data = i_store_data << (8*a), with the width masked before shifting.
- o_stall (combinational) = (state==REQ) | (IDLE & accepting a legal access). It is never asserted for exception-only accepts.
- In REQ with i_cache_done=1:
  - Next cycle: state IDLE, o_cache_req=0, o_cache_size=11.
  - Load: o_wb_valid=1 for one cycle, o_wb_data = extended lane of i_cache_data captured on the done cycle, o_wb_rd = registered rd.
  - Store: o_store_done=1 for one cycle.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend; LW passes the word through.
  - Lane shift is i_cache_data >> (8*a).
- Timeout:
  - Counter increments each REQ cycle without done.
  - When it reaches TIMEOUT_CYCLES: exception cause 11 next cycle, return to IDLE, drop request, no writeback.
  - A done arriving in the same cycle as the timeout wins; no exception is raised.
- i_cache_done outside REQ is ignored.
- Back-to-back: a new accept is possible in the cycle after returning to IDLE. The pipeline drives i_valid=0 in the pulse cycle unless it has advanced.
- o_wb_data and o_wb_rd hold their last values when o_wb_valid=0.

Test Plan:
1. LW at 0x100, cache done after 3 REQ cycles with data 0xDEADBEEF.
   -> o_stall high for 4 cycles; o_wb_valid pulses once with 0xDEADBEEF and the correct rd.
2. LB at 0x203, cache data 0x80112233.
   -> o_wb_data 0xFFFFFF80.
   LBU at the same address -> 0x00000080.
   LH at 0x202 -> 0xFFFF8011.
3. SB at 0x101, data 0x000000AB.
   -> o_cache_byte_en 0010, o_cache_write_data 0x0000AB00, o_cache_rw 1, o_cache_address 0x100.
   -> o_store_done pulses after done.
4. LW at 0x102, and SH at 0x001.
   -> no o_cache_req; o_exc_valid with cause 01 and 10 respectively; o_stall stays 0.
5. TIMEOUT_CYCLES=4, LW with no done.
   -> cause 11 after 4 REQ cycles.
   Repeat with done asserted on the 4th REQ cycle -> normal writeback, no exception.
6. Assert i_rst during the 2nd REQ cycle.
   -> next cycle o_cache_req 0, o_cache_size 11, all pulses 0.
   A later done is ignored.
